// File: rtl/crc5_frame_ctrl.sv
// rtl/crc5_frame_ctrl.sv - byte-stream CRC-5 trailer generator / checker
// Generate mode appends the frame CRC as a trailer byte; check mode verifies the last byte against it.
module crc5_frame_ctrl #(
  parameter logic [4:0] CRC_INIT = 5'h1F,
  parameter int         CNT_W    = 16
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             mode,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [4:0]       crc_out,
  output logic             err_valid,
  output logic             crc_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {IDLE, FRAME, TRAIL} state_t;

  state_t     state, state_nxt;
  logic       mode_q;
  logic [4:0] crc;

  logic       slot_free;
  logic       in_xfer;
  logic       mode_eff;
  logic [4:0] base;
  logic [4:0] crc_upd;
  logic       trail_load;
  logic       chk_last;
  logic       chk_bad;

  function automatic logic [4:0] crc_next(input logic [4:0] q, input logic [7:0] d);
    logic [4:0] n;
    n[0] = q[0] ^ q[2] ^ q[3] ^ d[0] ^ d[3] ^ d[5] ^ d[6];
    n[1] = q[1] ^ q[3] ^ q[4] ^ d[1] ^ d[4] ^ d[6] ^ d[7];
    n[2] = q[0] ^ q[3] ^ q[4] ^ d[0] ^ d[2] ^ d[3] ^ d[6] ^ d[7];
    n[3] = q[0] ^ q[1] ^ q[4] ^ d[1] ^ d[3] ^ d[4] ^ d[7];
    n[4] = q[1] ^ q[2] ^ d[2] ^ d[4] ^ d[5];
    return n;
  endfunction

  // The first byte of a frame uses the live mode pin and CRC_INIT; later bytes use latched state.
  assign slot_free  = !m_valid || m_ready;
  assign s_ready    = (state != TRAIL) && slot_free;
  assign in_xfer    = s_valid && s_ready;
  assign mode_eff   = (state == IDLE) ? mode : mode_q;
  assign base       = (state == IDLE) ? CRC_INIT : crc;
  assign crc_upd    = crc_next(base, s_data);
  assign trail_load = (state == TRAIL) && slot_free;
  assign chk_last   = in_xfer && mode_eff && s_last;
  assign chk_bad    = (s_data[4:0] != base) || (s_data[7:5] != 3'b000);
  assign crc_out    = crc;

  always_ff @(posedge ck) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FRAME: begin
        if (in_xfer) begin
          if (s_last) state_nxt = mode_eff ? IDLE : TRAIL;
          else        state_nxt = FRAME;
        end
      end
      TRAIL: begin
        if (slot_free) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      mode_q    <= 1'b0;
      crc       <= CRC_INIT;
      m_data    <= 8'h00;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      err_valid <= 1'b0;
      crc_err   <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= 8'h00;
    end else begin
      err_valid <= 1'b0;
      if (in_xfer && state == IDLE) mode_q <= mode;
      // The check-mode trailer is compared, never folded into the CRC.
      if (in_xfer && !chk_last) crc <= crc_upd;

      if (slot_free) begin
        if (in_xfer) begin
          m_data  <= s_data;
          m_valid <= 1'b1;
          m_last  <= chk_last;
        end else if (trail_load) begin
          m_data  <= {3'b000, crc};
          m_valid <= 1'b1;
          m_last  <= 1'b1;
        end else begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      end

      if (chk_last) begin
        err_valid <= 1'b1;
        crc_err   <= chk_bad;
        if (chk_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
      if (chk_last || trail_load) frame_cnt <= frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_crc5_frame_ctrl.sv
// tb/tb_crc5_frame_ctrl.sv - scoreboard bench for crc5_frame_ctrl
// Stimulus pushes expected output bytes and verdicts; a negedge monitor pops and compares.
module tb_crc5_frame_ctrl;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic [4:0]  crc_out;
  logic        err_valid;
  logic        crc_err;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] exp_q[$];
  logic       err_q[$];

  crc5_frame_ctrl dut (
    .ck(ck), .rst(rst), .mode(mode),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .crc_out(crc_out), .err_valid(err_valid), .crc_err(crc_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 ck = ~ck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge ck) begin : monitor
    logic [8:0] e;
    logic       ee;
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", {23'd0, m_last, m_data}, 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("out_byte", {23'd0, m_last, m_data}, {23'd0, e});
        end
      end
      if (err_valid) begin
        if (err_q.size() == 0) chk("unexpected_verdict", {31'd0, crc_err}, 32'hFFFF);
        else begin
          ee = err_q.pop_front();
          chk("verdict", {31'd0, crc_err}, {31'd0, ee});
        end
      end
    end
  end

  task automatic push_out(input logic [7:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic md);
    bit accepted = 0;
    int n = 0;
    s_data = d; s_last = last; mode = md; s_valid = 1'b1;
    while (!accepted && n < 100) begin
      @(negedge ck);
      accepted = s_ready;
      @(posedge ck); #1;
      n++;
    end
    if (!accepted) chk("accept_timeout", 0, 1);
  endtask

  // Up to three bytes; in generate mode trl is the expected trailer, in check mode bad is the verdict.
  task automatic run_frame(input logic md, input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [4:0] trl, input logic bad);
    logic [7:0] d;
    logic last;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      last = (i == n - 1);
      push_out(d, md ? last : 1'b0);
      if (last && !md) push_out({3'b000, trl}, 1'b1);
      if (last && md) err_q.push_back(bad);
      send_byte(d, last, md);
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && n < 100) begin
      @(posedge ck);
      n++;
    end
    #1;
    chk("drain", exp_q.size() + err_q.size(), 0);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge ck);
    #1 rst = 1'b0;
    @(negedge ck);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_crc", crc_out, 5'h1F);
    chk("rst_err", {err_valid, crc_err}, 0);
    chk("rst_cnts", {frame_cnt, err_cnt}, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge ck); #1;

    run_frame(0, 1, 8'h00, 8'h00, 8'h00, 5'h0F, 0);
    drain();
    chk("gen1_fc", frame_cnt, 1);

    run_frame(1, 2, 8'h00, 8'h0F, 8'h00, 5'h00, 0);
    drain();
    chk("chk_ok_cnt", {frame_cnt, err_cnt}, {16'd2, 8'd0});

    run_frame(1, 2, 8'h00, 8'h0E, 8'h00, 5'h00, 1);
    drain();
    chk("chk_bad_cnt", {frame_cnt, err_cnt}, {16'd3, 8'd1});
    chk("crc_err_held", crc_err, 1);

    run_frame(0, 1, 8'hA5, 8'h00, 8'h00, 5'h01, 0);
    drain();

    m_ready = 1'b0;
    push_out(8'h00, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    s_data = 8'hFF; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ck);
      chk("stall_s_ready", s_ready, 0);
      chk("stall_out", {m_valid, m_last, m_data}, {1'b1, 1'b0, 8'h00});
      chk("stall_fc", frame_cnt, 4);
      @(posedge ck); #1;
    end
    m_ready = 1'b1;
    push_out(8'hFF, 1'b0);
    push_out(8'h15, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b0);
    s_valid = 1'b0;
    drain();
    chk("stall_fc_after", frame_cnt, 5);

    run_frame(1, 3, 8'h00, 8'hFF, 8'h15, 5'h00, 0);
    run_frame(1, 1, 8'h1F, 8'h00, 8'h00, 5'h00, 0);
    run_frame(1, 1, 8'h3F, 8'h00, 8'h00, 5'h00, 1);
    run_frame(1, 2, 8'hA5, 8'h01, 8'h00, 5'h00, 0);
    drain();
    chk("mixed_cnt", {frame_cnt, err_cnt}, {16'd9, 8'd2});

    // mode flips to check on the second byte, but the frame stays in generate mode
    push_out(8'h00, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    push_out(8'hFF, 1'b0);
    push_out(8'h15, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b1);
    s_valid = 1'b0;
    drain();
    chk("mode_mid_fc", {frame_cnt, err_cnt}, {16'd10, 8'd2});

    push_out(8'h00, 1'b0);
    push_out(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    s_valid = 1'b0;
    drain();
    rst = 1'b1;
    repeat (2) @(posedge ck);
    #1 rst = 1'b0;
    @(negedge ck);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_state", {frame_cnt, err_cnt, 3'b000, crc_out}, {16'd0, 8'd0, 8'h1F});
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ck);
      if (m_valid) seen++;
    end
    chk("midrst_no_trailer", seen, 0);
    @(posedge ck); #1;
    run_frame(0, 1, 8'h00, 8'h00, 8'h00, 5'h0F, 0);
    drain();
    chk("midrst_fc", frame_cnt, 1);

    push_out(8'h00, 1'b0);
    push_out(8'h0F, 1'b1);
    push_out(8'h00, 1'b0);
    push_out(8'h0F, 1'b1);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    s_valid = 1'b0;
    drain();
    chk("b2b_fc", frame_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crc5_frame_ctrl.md
CRC5_FRAME_CTRL -- requirements
Module: crc5_frame_ctrl

Interface
REQ-001 Parameter CRC_INIT, default 5'h1F: CRC register value loaded at the start of every frame.
REQ-002 Parameter CNT_W, default 16: width of frame_cnt.
REQ-003 ck  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 mode  input  1  0 = generate (append CRC trailer), 1 = check (verify trailer); sampled only on the first byte of a frame.
REQ-006 s_data  input  8  input byte.
REQ-007 s_valid  input  1  input byte valid.
REQ-008 s_last  input  1  input byte is the last byte of its frame.
REQ-009 s_ready  output  1  block accepts the input byte this cycle.
REQ-010 m_data  output  8  output byte (registered).
REQ-011 m_valid  output  1  output byte valid (registered).
REQ-012 m_last  output  1  output byte is the last byte of its frame (registered).
REQ-013 m_ready  input  1  downstream accepts the output byte.
REQ-014 crc_out  output  5  current CRC register value.
REQ-015 err_valid  output  1  one-cycle pulse: check-mode verdict available.
REQ-016 crc_err  output  1  verdict of the last checked frame; held until the next verdict.
REQ-017 frame_cnt  output  CNT_W  completed frames (both modes); wraps modulo 2^CNT_W.
REQ-018 err_cnt  output  8  frames that failed the check; saturates at 255.

Function
REQ-019 Handshakes: an input transfer occurs when s_valid && s_ready; an output transfer occurs when m_valid && m_ready.
REQ-020 The output slot is free when !m_valid || m_ready.
REQ-021 The output register holds m_data, m_valid and m_last stable while m_valid && !m_ready.
REQ-022 CRC update f(q,d), where q is the CRC register and d the data byte:
- n0 = q0^q2^q3^d0^d3^d5^d6
- n1 = q1^q3^q4^d1^d4^d6^d7
- n2 = q0^q3^q4^d0^d2^d3^d6^d7
- n3 = q0^q1^q4^d1^d3^d4^d7
- n4 = q1^q2^d2^d4^d5
REQ-023 States: IDLE (awaiting first byte), FRAME (mid-frame), TRAIL (emitting the generate-mode trailer).
REQ-024 s_ready = (state != TRAIL) && output slot free.
REQ-025 Latency: an accepted input byte appears on m_data in the next cycle; there is no combinational path from s_* to m_*.
REQ-026 IDLE, on transfer: latch mode into mode_q.
- Base CRC value is CRC_INIT, not the current crc register value.
- Non-last byte -> FRAME.
- Last byte, mode_q = 0 -> TRAIL.
- Last byte, mode_q = 1 -> IDLE.
REQ-027 Generate mode, each accepted byte:
- crc <= f(base, byte), where base is CRC_INIT on the first byte and the crc register otherwise.
- Byte forwarded unchanged with m_last = 0.
- s_last causes the transition to TRAIL.
REQ-028 TRAIL: when the output slot is free, load m_data = {3'b000, crc}, m_last = 1, m_valid = 1; increment frame_cnt; go to IDLE.
REQ-029 Check mode, non-last bytes: crc <= f(base, byte); byte forwarded unchanged with m_last = 0.
REQ-030 Check mode, last byte (trailer):
- Byte forwarded with m_last = 1; crc register is not updated.
- crc_err <= (byte[4:0] != base) || (byte[7:5] != 0).
- err_valid pulses high in the following cycle.
- frame_cnt increments; err_cnt increments (saturating at 255) on error.
- State -> IDLE.
REQ-031 A one-byte frame in check mode compares against CRC_INIT.
REQ-032 A one-byte frame in generate mode produces the byte followed by its trailer.
REQ-033 Changing mode mid-frame has no effect until the next IDLE transfer.
REQ-034 A new frame's first byte is accepted in the cycle after the last byte or trailer is loaded; no idle cycle is needed between frames.
REQ-035 While m_valid && !m_ready: no input transfers occur and no state, CRC or counter changes occur.

Reset
REQ-036 rst has priority over all other activity, including a transfer in the same cycle.
REQ-037 On rst: state = IDLE, crc = CRC_INIT, mode_q = 0.
REQ-038 On rst: m_valid = 0, m_last = 0, m_data = 0.
REQ-039 On rst: err_valid = 0, crc_err = 0, frame_cnt = 0, err_cnt = 0.
REQ-040 A reset asserted mid-frame or in TRAIL discards the partial frame and emits no trailer.

Verification
REQ-041 Generate, mode=0, m_ready=1: single-byte frame 0x00 -> m_data 0x00 (m_last=0), then 0x0F (m_last=1); frame_cnt=1.
REQ-042 Check, mode=1: frame {0x00, 0x0F} -> both bytes forwarded; err_valid pulse with crc_err=0; err_cnt=0.
REQ-043 Check, mode=1: frame {0x00, 0x0E} -> err_valid pulse with crc_err=1; err_cnt=1.
REQ-044 Back-pressure: m_ready=0 for 5 cycles during a generate frame -> s_ready=0, outputs stable; after release, byte order and trailer unchanged.
REQ-045 Reset mid-frame: rst asserted after 2 bytes of a generate frame -> m_valid=0; next frame 0x00 -> trailer 0x0F.
REQ-046 Back-to-back frames: two one-byte generate frames with s_valid held high -> output 0x00, 0x0F, 0x00, 0x0F; frame_cnt=2.
